// File: rtl/note_gate_ctrl_if.sv
// -----------------------------------------------------------------------------
// note_gate_if
// Event handshake between the MIDI/event decoder (master) and the gate
// front end (slave).
//   ev_valid : event valid            (master -> slave)
//   ev_ready : slave can take event   (slave  -> master)
//   ev_on    : 1 = note-on, 0 = note-off
//   ev_note  : note number
//   ev_vel   : velocity (ignored on note-off)
// -----------------------------------------------------------------------------
interface note_gate_if;
   logic       ev_valid;
   logic       ev_ready;
   logic       ev_on;
   logic [6:0] ev_note;
   logic [6:0] ev_vel;

   modport master (output ev_valid, output ev_on, output ev_note, output ev_vel,
                   input  ev_ready);
   modport slave  (input  ev_valid, input  ev_on, input  ev_note, input  ev_vel,
                   output ev_ready);
endinterface

// File: rtl/note_gate_ctrl.sv
// -----------------------------------------------------------------------------
// note_gate_ctrl
// Event-to-gate front end for the envelope generator. Keeps a last-note-
// priority stack of held notes and drives gate/retrig, forcing a timed
// gate-low gap (counted in low_clk rising edges) when a new note arrives
// while the gate is already high, unless LEGATO is set.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   low_clk     : sample-rate square wave; rising edges count the gap
//   ev          : event handshake (slave side)
//   gate        : gate level to the envelope generator
//   retrig      : one-cycle pulse on each gate rising edge
//   note        : current (top-of-stack) note
//   velocity    : velocity of the current note
//   held_count  : number of valid stack entries
// -----------------------------------------------------------------------------
module note_gate_ctrl #(
   parameter int DEPTH      = 8,
   parameter int RETRIG_GAP = 2,
   parameter bit LEGATO     = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       low_clk,
   note_gate_if.slave ev,
   output logic       gate,
   output logic       retrig,
   output logic [6:0] note,
   output logic [6:0] velocity,
   output logic [4:0] held_count
);
   typedef enum logic       {E_IDLE, E_PROC} ev_state_t;
   typedef enum logic [1:0] {G_OFF, G_ON, G_GAP} gate_state_t;

   ev_state_t             ev_state_q, ev_state_d;
   logic                  ev_on_q, ev_on_d;
   logic [6:0]            ev_note_q, ev_note_d, ev_vel_q, ev_vel_d;
   logic [DEPTH-1:0][6:0] stk_note_q, stk_note_d, stk_vel_q, stk_vel_d;
   logic [4:0]            count_q, count_d;
   logic [DEPTH-1:0]      hit_vec;
   logic                  hit;
   logic [4:0]            hit_idx;
   logic                  proc;
   logic [6:0]            note_q, note_d, vel_q, vel_d;
   logic                  commit_on_q, commit_on_d, commit_empty_q, commit_empty_d;
   gate_state_t           gs_q, gs_d;
   logic [7:0]            gap_q, gap_d;
   logic                  gate_q, gate_d, retrig_q, retrig_d;
   logic                  low_clk_q, low_clk_d, low_rise;

   assign proc     = (ev_state_q == E_PROC);
   assign low_clk_d = low_clk;
   assign low_rise = low_clk & ~low_clk_q;

   // ---------------- event FSM ----------------
   always_comb begin
      ev_state_d  = ev_state_q;
      ev_on_d     = ev_on_q;
      ev_note_d   = ev_note_q;
      ev_vel_d    = ev_vel_q;
      ev.ev_ready = 1'b0;
      case (ev_state_q)
         E_IDLE: begin
            ev.ev_ready = 1'b1;
            if (ev.ev_valid) begin
               ev_state_d = E_PROC;
               ev_on_d    = ev.ev_on;
               ev_note_d  = ev.ev_note;
               ev_vel_d   = ev.ev_vel;
            end
         end
         default: ev_state_d = E_IDLE;
      endcase
   end

   // ---------------- held-note stack ----------------
   // At most one entry can match since a re-pressed note is removed before push.
   always_comb begin
      hit_idx = '0;
      for (int i = DEPTH - 1; i >= 0; i--)
         if (hit_vec[i]) hit_idx = 5'(i);
   end
   assign hit = |hit_vec;

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_ent
         logic [6:0] up_note, up_vel, dn_note, dn_vel;

         assign hit_vec[gi] = (5'(gi) < count_q) && (stk_note_q[gi] == ev_note_q);

         // Source for a push: the entry above, or the new event at the top.
         if (gi == 0) begin : g_top
            assign up_note = ev_note_q;
            assign up_vel  = ev_vel_q;
         end else begin : g_up
            assign up_note = stk_note_q[gi-1];
            assign up_vel  = stk_vel_q[gi-1];
         end

         // Source for a compaction: the entry below, or empty at the bottom.
         if (gi == DEPTH - 1) begin : g_bot
            assign dn_note = '0;
            assign dn_vel  = '0;
         end else begin : g_dn
            assign dn_note = stk_note_q[gi+1];
            assign dn_vel  = stk_vel_q[gi+1];
         end

         // Note-on: entries below a re-pressed note stay put, the rest shift down
         // (the oldest falls off when full). Note-off: entries below the hit shift up.
         always_comb begin
            stk_note_d[gi] = stk_note_q[gi];
            stk_vel_d[gi]  = stk_vel_q[gi];
            if (proc) begin
               if (ev_on_q) begin
                  if (!(hit && (5'(gi) > hit_idx))) begin
                     stk_note_d[gi] = up_note;
                     stk_vel_d[gi]  = up_vel;
                  end
               end else if (hit && (5'(gi) >= hit_idx)) begin
                  stk_note_d[gi] = dn_note;
                  stk_vel_d[gi]  = dn_vel;
               end
            end
         end
      end
   endgenerate

   always_comb begin
      count_d = count_q;
      if (proc) begin
         if (ev_on_q) begin
            if (!hit && (count_q != 5'(DEPTH))) count_d = count_q + 5'd1;
         end else if (hit) begin
            count_d = count_q - 5'd1;
         end
      end
   end

   // note/velocity follow the top entry but hold their value once the stack empties.
   always_comb begin
      note_d = note_q;
      vel_d  = vel_q;
      if (proc && (count_d != 5'd0) && (ev_on_q || hit)) begin
         note_d = stk_note_d[0];
         vel_d  = stk_vel_d[0];
      end
   end

   // Commit flags are registered so the gate FSM reacts one edge after the stack.
   assign commit_on_d    = proc & ev_on_q;
   assign commit_empty_d = proc & ~ev_on_q & hit & (count_q == 5'd1);

   // ---------------- gate FSM ----------------
   always_comb begin
      gs_d  = gs_q;
      gap_d = gap_q;
      case (gs_q)
         G_OFF: begin
            if (commit_on_q) gs_d = G_ON;
         end
         G_ON: begin
            if (commit_empty_q) begin
               gs_d = G_OFF;
            end else if (commit_on_q && !LEGATO) begin
               gs_d  = G_GAP;
               gap_d = 8'(RETRIG_GAP);
            end
         end
         G_GAP: begin
            if (commit_empty_q) begin
               gs_d  = G_OFF;
               gap_d = '0;
            end else if (commit_on_q) begin
               gap_d = 8'(RETRIG_GAP);      // reload beats a coincident low_clk edge
            end else if (low_rise) begin
               if (gap_q <= 8'd1) begin
                  gs_d  = G_ON;
                  gap_d = '0;
               end else begin
                  gap_d = gap_q - 8'd1;
               end
            end
         end
         default: begin
            gs_d  = G_OFF;
            gap_d = '0;
         end
      endcase
      gate_d   = (gs_d == G_ON);
      retrig_d = gate_d & ~gate_q;
   end

   // ---------------- registers ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ev_state_q     <= E_IDLE;
         ev_on_q        <= 1'b0;
         ev_note_q      <= '0;
         ev_vel_q       <= '0;
         stk_note_q     <= '0;
         stk_vel_q      <= '0;
         count_q        <= '0;
         note_q         <= '0;
         vel_q          <= '0;
         commit_on_q    <= 1'b0;
         commit_empty_q <= 1'b0;
         gs_q           <= G_OFF;
         gap_q          <= '0;
         gate_q         <= 1'b0;
         retrig_q       <= 1'b0;
         low_clk_q      <= 1'b0;
      end else begin
         ev_state_q     <= ev_state_d;
         ev_on_q        <= ev_on_d;
         ev_note_q      <= ev_note_d;
         ev_vel_q       <= ev_vel_d;
         stk_note_q     <= stk_note_d;
         stk_vel_q      <= stk_vel_d;
         count_q        <= count_d;
         note_q         <= note_d;
         vel_q          <= vel_d;
         commit_on_q    <= commit_on_d;
         commit_empty_q <= commit_empty_d;
         gs_q           <= gs_d;
         gap_q          <= gap_d;
         gate_q         <= gate_d;
         retrig_q       <= retrig_d;
         low_clk_q      <= low_clk_d;
      end
   end

   assign gate       = gate_q;
   assign retrig     = retrig_q;
   assign note       = note_q;
   assign velocity   = vel_q;
   assign held_count = count_q;
endmodule
